// File: rtl/led_cube_frame_buffer.sv
// Double-buffered 64-byte frame store feeding the cube driver; banks swap only at frame boundaries.
// Optional statistics counters are enabled by defining FB_STATS_EN.
module led_cube_frame_buffer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
`ifdef FB_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_sof,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              frame_done,
    output logic              front_valid,
    output logic              swap
`ifdef FB_STATS_EN
    ,
    output logic [CNT_W-1:0]  frames_shown,
    output logic [CNT_W-1:0]  sync_errors
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    logic [1:0]        wr_state_r;
    logic [1:0]        wr_state_nxt_s;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] wr_ptr_nxt_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic              wr_en_s;
    logic              pending_set_s;
    logic              transfer_s;
    logic              swap_cond_s;
    logic              bank_sel_r;
    logic              pending_r;
    logic              front_valid_r;
    logic              swap_r;
    logic [DATA_W-1:0] rd_word_s;
    logic [DATA_W-1:0] mem_r [0:2*DEPTH-1];

    assign wr_ready    = (wr_state_r != ST_FULL);
    assign transfer_s  = wr_valid && wr_ready;
    assign swap_cond_s = pending_r && (frame_done || !front_valid_r);
    assign front_valid = front_valid_r;
    assign swap        = swap_r;

    // Write FSM next-state: hunt for sof, fill sequentially, hold a full frame until swap.
    always_comb begin
        wr_state_nxt_s = wr_state_r;
        wr_ptr_nxt_s   = wr_ptr_r;
        wr_addr_s      = wr_ptr_r;
        wr_en_s        = 1'b0;
        pending_set_s  = 1'b0;
        case (wr_state_r)
            ST_IDLE: begin
                if (transfer_s && wr_sof) begin
                    wr_en_s        = 1'b1;
                    wr_addr_s      = ADDR_ZERO;
                    wr_ptr_nxt_s   = ADDR_ONE;
                    wr_state_nxt_s = ST_FILL;
                end else begin
                    wr_state_nxt_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (transfer_s && wr_sof) begin
                    // A new sof restarts the frame; the partial data is overwritten.
                    wr_en_s      = 1'b1;
                    wr_addr_s    = ADDR_ZERO;
                    wr_ptr_nxt_s = ADDR_ONE;
                end else if (transfer_s) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = wr_ptr_r;
                    if (wr_ptr_r == ADDR_LAST) begin
                        wr_ptr_nxt_s   = ADDR_ZERO;
                        wr_state_nxt_s = ST_FULL;
                        pending_set_s  = 1'b1;
                    end else begin
                        wr_ptr_nxt_s = wr_ptr_r + ADDR_ONE;
                    end
                end else begin
                    wr_state_nxt_s = ST_FILL;
                end
            end
            ST_FULL: begin
                if (swap_cond_s) begin
                    wr_state_nxt_s = ST_IDLE;
                    wr_ptr_nxt_s   = ADDR_ZERO;
                end else begin
                    wr_state_nxt_s = ST_FULL;
                end
            end
            default: begin
                wr_state_nxt_s = ST_IDLE;
                wr_ptr_nxt_s   = ADDR_ZERO;
            end
        endcase
    end

    // Write FSM state and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_r <= ST_IDLE;
            wr_ptr_r   <= ADDR_ZERO;
        end else begin
            wr_state_r <= wr_state_nxt_s;
            wr_ptr_r   <= wr_ptr_nxt_s;
        end
    end

    // Bank exchange control: pending frame, front validity, bank select and swap pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_sel_r    <= 1'b0;
            pending_r     <= 1'b0;
            front_valid_r <= 1'b0;
            swap_r        <= 1'b0;
        end else begin
            swap_r <= swap_cond_s;
            if (swap_cond_s) begin
                bank_sel_r    <= ~bank_sel_r;
                pending_r     <= 1'b0;
                front_valid_r <= 1'b1;
            end else if (pending_set_s) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

    // Frame storage; only the back bank is ever written, contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[{~bank_sel_r, wr_addr_s}] <= wr_data;
        end
    end

    assign rd_word_s = mem_r[{bank_sel_r, rd_addr}];

    // Front-bank read, blanked until a complete frame has been shown.
    always_comb begin
        rd_data = {DATA_W{1'b0}};
        if (front_valid_r) begin
            rd_data = rd_word_s;
        end else begin
            rd_data = {DATA_W{1'b0}};
        end
    end

`ifdef FB_STATS_EN
    logic sync_err_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == {CNT_W{1'b1}}) begin
            return value;
        end else begin
            return value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign sync_err_s = transfer_s &&
                        (((wr_state_r == ST_IDLE) && !wr_sof) ||
                         ((wr_state_r == ST_FILL) && wr_sof));

    // Saturating statistics: frames presented and stream sync losses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_shown <= {CNT_W{1'b0}};
            sync_errors  <= {CNT_W{1'b0}};
        end else begin
            if (swap_cond_s) begin
                frames_shown <= sat_inc(frames_shown);
            end else begin
                frames_shown <= frames_shown;
            end
            if (sync_err_s) begin
                sync_errors <= sat_inc(sync_errors);
            end else begin
                sync_errors <= sync_errors;
            end
        end
    end
`endif

endmodule

// File: tb/tb_led_cube_frame_buffer.sv
// Self-checking bench for led_cube_frame_buffer: directed corner cases, a vector table and
// randomized traffic against a frame-level reference model.
module tb_led_cube_frame_buffer;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       wr_sof;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_done;
    logic       front_valid;
    logic       swap;
`ifdef FB_STATS_EN
    logic [15:0] frames_shown;
    logic [15:0] sync_errors;
`endif

    led_cube_frame_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_sof     (wr_sof),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_done (frame_done),
        .front_valid(front_valid),
        .swap       (swap)
`ifdef FB_STATS_EN
        ,
        .frames_shown(frames_shown),
        .sync_errors (sync_errors)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks;
    int failures;

    // Reference model: frames as whole byte arrays
    logic [7:0] asm_buf [64];
    logic [7:0] ready_buf [64];
    logic [7:0] shown [64];
    int         asm_cnt;
    bit         have_ready;
    bit         shown_valid;
    bit         exp_swap;
    int         exp_frames;
    int         exp_errs;

    typedef struct {
        logic       valid;
        logic       sof;
        logic [7:0] data;
        logic       done;
        logic [5:0] raddr;
        logic       e_ready;
        logic       e_swap;
        logic       e_fv;
        logic [7:0] e_rd;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        asm_cnt     = 0;
        have_ready  = 1'b0;
        shown_valid = 1'b0;
        exp_swap    = 1'b0;
        exp_frames  = 0;
        exp_errs    = 0;
    endtask

    task automatic model_step(input logic v, input logic s, input logic [7:0] d, input logic dn);
        bit xfer;
        xfer     = v && !have_ready;
        exp_swap = 1'b0;
        if (have_ready && (dn || !shown_valid)) begin
            shown       = ready_buf;
            shown_valid = 1'b1;
            have_ready  = 1'b0;
            exp_swap    = 1'b1;
            if (exp_frames != 65535) exp_frames++;
        end
        if (xfer) begin
            if (s) begin
                if (asm_cnt > 0 && exp_errs != 65535) exp_errs++;
                asm_buf[0] = d;
                asm_cnt    = 1;
            end else if (asm_cnt > 0) begin
                asm_buf[asm_cnt] = d;
                asm_cnt++;
            end else begin
                if (exp_errs != 65535) exp_errs++;
            end
            if (asm_cnt == 64) begin
                ready_buf  = asm_buf;
                have_ready = 1'b1;
                asm_cnt    = 0;
            end
        end
    endtask

    task automatic do_cycle(input logic v, input logic s, input logic [7:0] d,
                            input logic dn, input logic [5:0] ra);
        logic [7:0] exp_rd;
        @(negedge clk);
        wr_valid   = v;
        wr_sof     = s;
        wr_data    = d;
        frame_done = dn;
        rd_addr    = ra;
        @(posedge clk);
        model_step(v, s, d, dn);
        #1;
        exp_rd = shown_valid ? shown[ra] : 8'h00;
        check("wr_ready", {31'd0, wr_ready}, {31'd0, !have_ready});
        check("swap", {31'd0, swap}, {31'd0, exp_swap});
        check("front_valid", {31'd0, front_valid}, {31'd0, shown_valid});
        check("rd_data", {24'd0, rd_data}, {24'd0, exp_rd});
`ifdef FB_STATS_EN
        check("frames_shown", {16'd0, frames_shown}, exp_frames);
        check("sync_errors", {16'd0, sync_errors}, exp_errs);
`endif
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst        = 1'b1;
        wr_valid   = 1'b0;
        wr_sof     = 1'b0;
        frame_done = 1'b0;
        #1;
        check("rst_front_valid", {31'd0, front_valid}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("rst_swap", {31'd0, swap}, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int e0;
        logic [7:0] b;
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        wr_valid   = 1'b0;
        wr_sof     = 1'b0;
        wr_data    = 8'h00;
        frame_done = 1'b0;
        rd_addr    = 6'd0;
        model_reset();
        e0 = 0;

        tbl[0] = '{1'b1, 1'b0, 8'h11, 1'b0, 6'd5, 1'b0, 1'b0, 1'b1, 8'h05};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 6'd5, 1'b1, 1'b1, 1'b1, 8'h85};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 6'd5, 1'b1, 1'b0, 1'b1, 8'h85};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 6'd6, 1'b1, 1'b0, 1'b1, 8'h86};
        tbl[4] = '{1'b1, 1'b0, 8'h33, 1'b0, 6'd7, 1'b1, 1'b0, 1'b1, 8'h87};

        apply_reset();

        // Test 1: first frame swaps one cycle after the 64th byte
        for (int n = 0; n < 64; n++) do_cycle(1'b1, (n == 0), n[7:0], 1'b0, 6'd0);
        check("t1_no_swap_at_last", {31'd0, swap}, 32'd0);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b0, 6'h2A);
        check("t1_swap_pulse", {31'd0, swap}, 32'd1);
        check("t1_front_valid", {31'd0, front_valid}, 32'd1);
        check("t1_rd_2a", {24'd0, rd_data}, 32'h2A);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b0, 6'h2A);
        check("t1_swap_one_cycle", {31'd0, swap}, 32'd0);

        // Test 2: second frame held until frame_done, then vector table
        for (int n = 0; n < 64; n++) do_cycle(1'b1, (n == 0), 8'h80 | n[7:0], 1'b0, 6'd5);
        for (int i = 0; i < 5; i++) begin
            do_cycle(tbl[i].valid, tbl[i].sof, tbl[i].data, tbl[i].done, tbl[i].raddr);
            check("tbl_ready", {31'd0, wr_ready}, {31'd0, tbl[i].e_ready});
            check("tbl_swap", {31'd0, swap}, {31'd0, tbl[i].e_swap});
            check("tbl_fv", {31'd0, front_valid}, {31'd0, tbl[i].e_fv});
            check("tbl_rd", {24'd0, rd_data}, {24'd0, tbl[i].e_rd});
        end

        // Test 3: sof re-asserted at byte 20, then 64 bytes of 0xAA
        e0 = exp_errs;
        for (int n = 0; n < 20; n++) do_cycle(1'b1, (n == 0), 8'h40 + n[7:0], 1'b0, 6'd0);
        for (int n = 0; n < 64; n++) do_cycle(1'b1, (n == 0), 8'hAA, 1'b0, 6'd0);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b1, 6'd0);
        check("t3_swap", {31'd0, swap}, 32'd1);
        for (int a = 0; a < 64; a++) begin
            do_cycle(1'b0, 1'b0, 8'h00, 1'b0, a[5:0]);
            check("t3_rd_aa", {24'd0, rd_data}, 32'hAA);
        end
`ifdef FB_STATS_EN
        check("t3_sync_err_delta", {16'd0, sync_errors}, e0 + 1);
`endif

        // Test 4: bytes without sof after reset are dropped
        apply_reset();
        for (int n = 0; n < 3; n++) do_cycle(1'b1, 1'b0, 8'hC0 + n[7:0], 1'b0, 6'd0);
        for (int a = 0; a < 64; a++) begin
            do_cycle(1'b0, 1'b0, 8'h00, 1'b0, a[5:0]);
            check("t4_rd_zero", {24'd0, rd_data}, 32'd0);
        end
        check("t4_fv_low", {31'd0, front_valid}, 32'd0);
        for (int n = 0; n < 64; n++) do_cycle(1'b1, (n == 0), n[7:0] * 8'd3, 1'b0, 6'd0);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b0, 6'd9);
        check("t4_swap", {31'd0, swap}, 32'd1);
        check("t4_rd_9", {24'd0, rd_data}, 32'd27);

        // Test 5: frame_done coincident with the 64th write does not swap
        for (int n = 0; n < 64; n++) do_cycle(1'b1, (n == 0), n[7:0] ^ 8'h5A, (n == 63), 6'd3);
        check("t5_no_swap_coincident", {31'd0, swap}, 32'd0);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b0, 6'd3);
        check("t5_still_waiting", {31'd0, swap}, 32'd0);
        check("t5_old_frame", {24'd0, rd_data}, 32'd9);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b1, 6'd3);
        check("t5_swap_next_done", {31'd0, swap}, 32'd1);
        check("t5_new_frame", {24'd0, rd_data}, {24'd0, 8'h03 ^ 8'h5A});

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            b = 8'($urandom_range(0, 255));
            do_cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 2), b,
                     ($urandom_range(0, 9) == 0), 6'($urandom_range(0, 63)));
        end

        // Test 6: asynchronous reset mid-fill with a valid front frame
        for (int n = 0; n < 64; n++) do_cycle(1'b1, (n == 0), 8'h10 + n[7:0], 1'b0, 6'd0);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b1, 6'd0);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b1, 6'd0);
        for (int n = 0; n < 30; n++) do_cycle(1'b1, (n == 0), 8'hE0, 1'b0, 6'd4);
        check("t6_fv_before", {31'd0, front_valid}, 32'd1);
        check("t6_rd_before", {24'd0, rd_data}, 32'h14);
        #2;
        rst = 1'b1;
        #1;
        check("t6_fv_async", {31'd0, front_valid}, 32'd0);
        check("t6_rd_async", {24'd0, rd_data}, 32'd0);
        check("t6_ready_async", {31'd0, wr_ready}, 32'd1);
        check("t6_swap_async", {31'd0, swap}, 32'd0);
        model_reset();
        wr_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_cycle(1'b1, 1'b0, 8'h77, 1'b0, 6'd4);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b1, 6'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
